// File: rtl/sram_dp_clr_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_clr_if
//  Description : Bus bundle for the dual-port clearing SRAM. Port A is the
//                read/write load/store port, port B is the read-only fetch
//                or debug port; BUSY reports the post-reset clear sequence.
//  Signals     : WE, WMASK, A, Din  - port A write controls and data
//                DoutA              - port A read data
//                B, DoutB           - port B read address and data
//                BUSY               - clear sequence in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_dp_clr_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic                  WE;
   logic [DATA_W/8-1:0]   WMASK;
   logic [ADDR_W-1:0]     A;
   logic [DATA_W-1:0]     Din;
   logic [DATA_W-1:0]     DoutA;
   logic [ADDR_W-1:0]     B;
   logic [DATA_W-1:0]     DoutB;
   logic                  BUSY;

   // Memory-user side
   modport master (
      output WE, WMASK, A, Din, B,
      input  DoutA, DoutB, BUSY
   );

   // Memory side
   modport slave (
      input  WE, WMASK, A, Din, B,
      output DoutA, DoutB, BUSY
   );
endinterface : sram_dp_clr_if
`default_nettype wire

// File: rtl/sram_dp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_clr
//  Description : 2**ADDR_W x DATA_W SRAM with one read/write port (A), one
//                read-only port (B), per-byte write masks, selectable
//                combinational (RD_LAT=0) or registered write-first
//                (RD_LAT=1) reads, and a clear sequencer that fills every
//                word with INIT_VAL after reset.
//  Ports       : CLK  - clock, all state updates on the rising edge
//                RST  - synchronous active-high reset, starts the clear
//                bus  - sram_dp_clr_if slave modport (WE, WMASK, A, Din,
//                       DoutA, B, DoutB, BUSY)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_clr #(
   parameter int                DATA_W   = 16,   // multiple of 8
   parameter int                ADDR_W   = 16,
   parameter int                RD_LAT   = 0,    // 0 = comb read, 1 = registered
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  wire          CLK,
   input  wire          RST,
   sram_dp_clr_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NLANE = DATA_W / 8;

   localparam logic [0:0]      c_IDLE  = 1'b0;
   localparam logic [0:0]      c_CLEAR = 1'b1;
   // Counter is one bit wider than the address; the terminal value is the
   // last address with the extra bit clear.
   localparam logic [ADDR_W:0] c_LAST  = {1'b0, {ADDR_W{1'b1}}};

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [0:0]        r_state;
   logic [ADDR_W:0]   r_cnt;
   logic              r_busy;

   logic              w_clr;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [NLANE-1:0]  w_wmask;
   logic [DATA_W-1:0] w_douta;
   logic [DATA_W-1:0] w_doutb;

   // ------------------------------------------------------------------
   // Clear sequencer: one word per cycle, DEPTH cycles after the RST edge
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= c_CLEAR;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else if (r_state == c_CLEAR) begin
         r_cnt <= r_cnt + (ADDR_W+1)'(1);
         if (r_cnt == c_LAST) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Single write port shared by the sequencer and port A. The RST edge
   // itself never writes; the clear that follows overwrites everything.
   // ------------------------------------------------------------------
   always_comb begin
      w_clr   = (r_state == c_CLEAR) && !RST;
      w_we    = !RST && (w_clr || ((r_state == c_IDLE) && bus.WE));
      w_addr  = w_clr ? r_cnt[ADDR_W-1:0] : bus.A;
      w_wdata = w_clr ? INIT_VAL          : bus.Din;
      w_wmask = w_clr ? {NLANE{1'b1}}     : bus.WMASK;
   end

   always_ff @(posedge CLK) begin
      if (w_we) begin
         for (int i = 0; i < NLANE; i++) begin
            if (w_wmask[i]) begin
               r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read paths
   // ------------------------------------------------------------------
   generate
      if (RD_LAT == 0) begin : g_rd_comb
         assign w_douta = r_busy ? '0 : r_mem[bus.A];
         assign w_doutb = r_busy ? '0 : r_mem[bus.B];
      end else begin : g_rd_reg
         logic [DATA_W-1:0] w_mrg_a;
         logic [DATA_W-1:0] w_mrg_b;
         logic [DATA_W-1:0] r_douta;
         logic [DATA_W-1:0] r_doutb;

         // Write-first: a lane being written this edge is forwarded into
         // the registered read of the same address.
         always_comb begin
            w_mrg_a = r_mem[bus.A];
            w_mrg_b = r_mem[bus.B];
            for (int i = 0; i < NLANE; i++) begin
               if (w_we && w_wmask[i] && (w_addr == bus.A)) begin
                  w_mrg_a[8*i +: 8] = w_wdata[8*i +: 8];
               end
               if (w_we && w_wmask[i] && (w_addr == bus.B)) begin
                  w_mrg_b[8*i +: 8] = w_wdata[8*i +: 8];
               end
            end
         end

         // Sampling while busy loads zero, so outputs stay 0 for the
         // whole clear and for the first cycle after BUSY falls.
         always_ff @(posedge CLK) begin
            if (RST || r_busy) begin
               r_douta <= '0;
               r_doutb <= '0;
            end else begin
               r_douta <= w_mrg_a;
               r_doutb <= w_mrg_b;
            end
         end

         assign w_douta = r_douta;
         assign w_doutb = r_doutb;
      end
   endgenerate

   assign bus.DoutA = w_douta;
   assign bus.DoutB = w_doutb;
   assign bus.BUSY  = r_busy;

endmodule : sram_dp_clr
`default_nettype wire
